// File: rtl/alu_seq_core.sv
// Registered 8-bit ALU with an 8-iteration shift-add multiplier and valid/ready handshakes.
// Each completed result is held with its operands and opcode until the consumer accepts it.
module alu_seq_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic [4:0] choice_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] a_q,
    output logic [7:0] b_q,
    output logic [4:0] choice_q,
    output logic [7:0] result,
    output logic       carry_out,
    output logic [7:0] product_hi
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00011;
    localparam logic [4:0] OP_OR  = 5'b00100;
    localparam logic [4:0] OP_XOR = 5'b00101;
    localparam logic [4:0] OP_INC = 5'b01111;
    localparam logic [4:0] OP_DEC = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_d, out_valid_d;
    logic [7:0]  a_d, b_d, result_d, product_hi_d;
    logic [4:0]  choice_d;
    logic        carry_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] acc_sum;

    // Returns {carry, result}; SUB/DEC bit 8 of the 9-bit difference is the borrow.
    function automatic logic [8:0] alu_single(input logic [7:0] a, input logic [7:0] b,
                                              input logic [4:0] op);
        logic [8:0] r;
        r = 9'd0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_INC:  r = {1'b0, a} + 9'd1;
            OP_DEC:  r = {1'b0, a} - 9'd1;
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 16'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            choice_q   <= 5'b00000;
            result     <= 8'h00;
            carry_out  <= 1'b0;
            product_hi <= 8'h00;
            acc_q      <= 16'h0000;
            mcand_q    <= 16'h0000;
            mplier_q   <= 8'h00;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            choice_q   <= choice_d;
            result     <= result_d;
            carry_out  <= carry_d;
            product_hi <= product_hi_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (choice_in == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:   if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        choice_d     = choice_q;
        result_d     = result;
        carry_d      = carry_out;
        product_hi_d = product_hi;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    choice_d = choice_in;
                    if (choice_in == OP_MUL) begin
                        acc_d    = 16'h0000;
                        mcand_d  = {8'h00, a_in};
                        mplier_d = b_in;
                        cnt_d    = 3'd0;
                    end else begin
                        {carry_d, result_d} = alu_single(a_in, b_in, choice_in);
                        product_hi_d        = 8'h00;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                // Visible outputs only change once the product is complete.
                if (cnt_q == 3'd7) begin
                    result_d     = acc_sum[7:0];
                    product_hi_d = acc_sum[15:8];
                    carry_d      = |acc_sum[15:8];
                end
            end
            default: ;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

endmodule
